// File: rtl/rf_mp_scoreboard.sv
// rtl/rf_mp_scoreboard.sv - multi-port register file with write-first bypass and per-register busy scoreboard
module rf_mp_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       rsv_en,
  input  logic [ADDR_W-1:0]          rsv_addr,
  output logic [(1<<ADDR_W)-1:0]     busy_vec
);

  localparam int DEPTH = 1 << ADDR_W;

  // Packed storage so reset and indexing use exact-width addresses
  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [DEPTH-1:0]             busy;

  // Address 0 is inert when the zero register is enabled
  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Writes in port order so the highest-index port wins a same-address conflict;
  // the reserve is applied last so a new producer outlives a retiring one
  always_ff @(posedge clk) begin
    if (rst) begin
      mem  <= '0;
      busy <= '0;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_en[k] && !is_zero(wr_addr[k*ADDR_W +: ADDR_W])) begin
          mem[wr_addr[k*ADDR_W +: ADDR_W]]  <= wr_data[k*DATA_W +: DATA_W];
          busy[wr_addr[k*ADDR_W +: ADDR_W]] <= 1'b0;
        end
      end
      if (rsv_en && !is_zero(rsv_addr)) begin
        busy[rsv_addr] <= 1'b1;
      end
    end
  end

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rdat;
    logic              rbusy;
    logic              hit;

    assign ra = rd_addr[j*ADDR_W +: ADDR_W];

    // Write-first read: the winning same-cycle write is forwarded and masks the busy bit
    always_comb begin
      hit  = 1'b0;
      rdat = mem[ra];
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_en[k] && (wr_addr[k*ADDR_W +: ADDR_W] == ra)) begin
          hit  = 1'b1;
          rdat = wr_data[k*DATA_W +: DATA_W];
        end
      end
      rbusy = busy[ra] & ~hit;
      if (is_zero(ra)) begin
        rdat  = '0;
        rbusy = 1'b0;
      end
    end

    assign rd_data[j*DATA_W +: DATA_W] = rdat;
    assign rd_busy[j]                  = rbusy;
  end

  // Bit 0 is masked as well, so the zero register can never appear busy
  always_comb begin
    busy_vec = busy;
    if (ZERO_REG != 0) begin
      busy_vec[0] = 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_mp_scoreboard.sv
// tb/tb_rf_mp_scoreboard.sv - directed table-driven bench for rf_mp_scoreboard
module tb_rf_mp_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [9:0]  rd_addr;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic [63:0] rd_data,  rd_data_z;
  logic [1:0]  rd_busy,  rd_busy_z;
  logic [31:0] busy_vec, busy_vec_z;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rf_mp_scoreboard #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(busy_vec)
  );

  rf_mp_scoreboard #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(0)) dut_z (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_z), .rd_busy(rd_busy_z),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(busy_vec_z)
  );

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        rv;
    logic [4:0]  rva;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  eb;
    logic [31:0] ebv;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic [4:0] wa1, input logic [31:0] wd1,
                       input logic rv, input logic [4:0] rva,
                       input logic [4:0] ra0, input logic [4:0] ra1);
    wr_en    = we;
    wr_addr  = {wa1, wa0};
    wr_data  = {wd1, wd0};
    rsv_en   = rv;
    rsv_addr = rva;
    rd_addr  = {ra1, ra0};
  endtask

  task automatic idle(input logic [4:0] ra0, input logic [4:0] ra1);
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, ra0, ra1);
  endtask

  // Advance one clock and land 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                              input logic [4:0] wa1, input logic [31:0] wd1,
                              input logic rv, input logic [4:0] rva,
                              input logic [4:0] ra0, input logic [4:0] ra1,
                              input logic [31:0] e0, input logic [31:0] e1,
                              input logic [1:0] eb, input logic [31:0] ebv);
    vec_t v;
    v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.rv = rv; v.rva = rva; v.ra0 = ra0; v.ra1 = ra1;
    v.e0 = e0; v.e1 = e1; v.eb = eb; v.ebv = ebv;
    return v;
  endfunction

  initial begin
    // Sequence after reset; expectations are sampled before the edge of each row
    //               we    wa0  wd0      wa1  wd1     rv  rva  ra0  ra1  e0       e1       eb     ebv
    tbl.push_back(mk(2'b00, 0,  0,       0,  0,       0,  0,   15,  7,   0,       0,       2'b00, 32'h0));
    tbl.push_back(mk(2'b01, 15, 52,      0,  0,       0,  0,   15,  0,   52,      0,       2'b00, 32'h0));
    tbl.push_back(mk(2'b00, 0,  0,       0,  0,       0,  0,   15,  7,   52,      0,       2'b00, 32'h0));
    tbl.push_back(mk(2'b11, 7,  32'h11,  7,  32'h22,  0,  0,   7,   15,  32'h22,  52,      2'b00, 32'h0));
    tbl.push_back(mk(2'b00, 0,  0,       0,  0,       0,  0,   7,   7,   32'h22,  32'h22,  2'b00, 32'h0));
    tbl.push_back(mk(2'b01, 0,  624,     0,  0,       0,  0,   0,   0,   0,       0,       2'b00, 32'h0));
    tbl.push_back(mk(2'b00, 0,  0,       0,  0,       0,  0,   0,   7,   0,       32'h22,  2'b00, 32'h0));
    tbl.push_back(mk(2'b00, 0,  0,       0,  0,       1,  9,   9,   9,   0,       0,       2'b00, 32'h0));
    tbl.push_back(mk(2'b00, 0,  0,       0,  0,       0,  0,   9,   9,   0,       0,       2'b11, 32'h200));
    tbl.push_back(mk(2'b10, 0,  0,       9,  5,       0,  0,   9,   7,   5,       32'h22,  2'b00, 32'h200));
    tbl.push_back(mk(2'b00, 0,  0,       0,  0,       0,  0,   9,   9,   5,       5,       2'b00, 32'h0));
    tbl.push_back(mk(2'b01, 3,  32'hAB,  0,  0,       1,  3,   3,   9,   32'hAB,  5,       2'b00, 32'h0));
    tbl.push_back(mk(2'b00, 0,  0,       0,  0,       0,  0,   3,   3,   32'hAB,  32'hAB,  2'b11, 32'h8));
    tbl.push_back(mk(2'b00, 0,  0,       0,  0,       1,  3,   3,   9,   32'hAB,  5,       2'b01, 32'h8));
    tbl.push_back(mk(2'b00, 0,  0,       0,  0,       0,  0,   3,   9,   32'hAB,  5,       2'b01, 32'h8));
    tbl.push_back(mk(2'b00, 0,  0,       0,  0,       1,  0,   0,   3,   0,       32'hAB,  2'b10, 32'h8));
    tbl.push_back(mk(2'b00, 0,  0,       0,  0,       0,  0,   0,   3,   0,       32'hAB,  2'b10, 32'h8));
    tbl.push_back(mk(2'b11, 20, 32'hA0,  21, 32'hA1,  0,  0,   20,  21,  32'hA0,  32'hA1,  2'b00, 32'h8));
    tbl.push_back(mk(2'b00, 0,  0,       0,  0,       0,  0,   21,  20,  32'hA1,  32'hA0,  2'b00, 32'h8));

    rst = 1'b1;
    idle(0, 0);
    tick();
    tick();
    rst = 1'b0;

    // Scatter writes and reservations, then reset and confirm everything is cleared
    for (int i = 0; i < 8; i++) begin
      drive(2'b11, 5'(i * 4 + 1), $urandom, 5'(i * 4 + 2), $urandom, 1'b1, 5'(i * 4 + 3), 0, 0);
      tick();
    end
    rst = 1'b1;
    drive(2'b11, 5'd10, 32'hDEAD, 5'd11, 32'hBEEF, 1'b1, 5'd12, 0, 0);
    tick();
    rst = 1'b0;
    idle(0, 0);
    #1;
    chk("reset_busy_vec", busy_vec, 0);
    for (int i = 0; i < 16; i++) begin
      idle(5'(2 * i), 5'(2 * i + 1));
      #1;
      chk($sformatf("reset_rd_r%0d_r%0d", 2 * i, 2 * i + 1), rd_data, 0);
      chk($sformatf("reset_busy_r%0d_r%0d", 2 * i, 2 * i + 1), rd_busy, 0);
    end
    tick();

    foreach (tbl[n]) begin
      drive(tbl[n].we, tbl[n].wa0, tbl[n].wd0, tbl[n].wa1, tbl[n].wd1,
            tbl[n].rv, tbl[n].rva, tbl[n].ra0, tbl[n].ra1);
      #3;
      chk($sformatf("vec%0d_rd0", n), rd_data[31:0], tbl[n].e0);
      chk($sformatf("vec%0d_rd1", n), rd_data[63:32], tbl[n].e1);
      chk($sformatf("vec%0d_busy", n), rd_busy, tbl[n].eb);
      chk($sformatf("vec%0d_busy_vec", n), busy_vec, tbl[n].ebv);
      tick();
    end

    // Zero register on vs off: dut_z saw the same stream, so reg0 held 624 and is reserved
    idle(0, 0);
    #1;
    chk("z_reg0_prev", rd_data_z[31:0], 624);
    chk("z_reg0_busy_prev", rd_busy_z[0], 1);
    drive(2'b01, 5'd0, 32'd624, 5'd0, 32'd0, 1'b0, 5'd0, 0, 0);
    #1;
    chk("zr_bypass_reg0", rd_data[31:0], 0);
    chk("z_bypass_reg0", rd_data_z[31:0], 624);
    chk("z_bypass_busy", rd_busy_z[0], 0);
    tick();
    idle(0, 0);
    #1;
    chk("zr_next_reg0", rd_data[31:0], 0);
    chk("z_next_reg0", rd_data_z[31:0], 624);
    chk("z_next_bv0", busy_vec_z[0], 0);
    drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd0, 0, 0);
    tick();
    idle(0, 0);
    #1;
    chk("zr_rsv0_bv", busy_vec[0], 0);
    chk("zr_rsv0_busy", rd_busy[0], 0);
    chk("z_rsv0_bv", busy_vec_z[0], 1);
    chk("z_rsv0_busy", rd_busy_z[0], 1);

    // Reset mid-operation overrides concurrent writes and reserves
    rst = 1'b1;
    drive(2'b11, 5'd5, 32'h55, 5'd6, 32'h66, 1'b1, 5'd7, 3, 5);
    tick();
    rst = 1'b0;
    idle(3, 5);
    #1;
    chk("midrst_busy_vec", busy_vec, 0);
    chk("midrst_busy_vec_z", busy_vec_z, 0);
    chk("midrst_rd", rd_data, 0);
    chk("midrst_busy", rd_busy, 0);
    idle(6, 7);
    #1;
    chk("midrst_rd67", rd_data, 0);
    chk("midrst_busy67", rd_busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
